// File: rtl/io_pkg.sv
// io_pkg: shared widths, I/O address select bit and debounce FSM states for the board I/O stage
package io_pkg;
    localparam int SW_W       = 8;
    localparam int LED_W      = 8;
    localparam int IO_SEL_BIT = 8;
    localparam int ADDR_W     = 13;
    typedef enum logic {IDLE, COUNT} state_t;
endpackage

// File: rtl/io_sync_2ff.sv
// io_sync_2ff: two-flop synchroniser for asynchronous inputs, sync active-high reset to 0
module io_sync_2ff #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/sw_led_io_ctrl.sv
// sw_led_io_ctrl: switch synchronise/debounce, LED register and sticky change flag on the I/O path.
// Optional SW_EDGE_LATCH_EN adds sw_rise, sticky per-bit rising edges of sw_stable.
module sw_led_io_ctrl
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   sw_pad,
    input  logic [ADDR_W-1:0] addr,
    input  logic              mem_wr,
    input  logic              mem_rd,
    input  logic [LED_W-1:0]  wr_data,
    output logic [SW_W-1:0]   sw_stable,
    output logic              sw_changed,
    output logic [LED_W-1:0]  led_pad
`ifdef SW_EDGE_LATCH_EN
    ,
    output logic [SW_W-1:0]   sw_rise
`endif
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  sw_sync, cand;
    logic [CNT_W-1:0] cnt;
    state_t           state;
    logic             io_wr, io_rd, upd, unused_addr;

    io_sync_2ff #(.W(SW_W)) u_sync (.clk(clk), .rst(rst), .d(sw_pad), .q(sw_sync));

    assign io_wr       = mem_wr & ~mem_rd & addr[IO_SEL_BIT];
    assign io_rd       = mem_rd & ~mem_wr & addr[IO_SEL_BIT];
    assign unused_addr = ^{addr[ADDR_W-1:IO_SEL_BIT+1], addr[IO_SEL_BIT-1:0]};
    // Same condition under which the FSM commits cand to sw_stable
    assign upd = (state == COUNT) && (sw_sync != sw_stable) && (sw_sync == cand) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            sw_stable <= '0;
        end else if (state == IDLE) begin
            if (sw_sync != sw_stable) begin
                state <= COUNT;
                cand  <= sw_sync;
                cnt   <= '0;
            end
        end else if (sw_sync == sw_stable) begin
            state <= IDLE;
        end else if (sw_sync != cand) begin
            cand <= sw_sync;
            cnt  <= '0;
        end else if (cnt == LAST) begin
            sw_stable <= cand;
            state     <= IDLE;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_changed <= 1'b0;
            led_pad    <= '0;
        end else begin
            sw_changed <= upd | (sw_changed & ~io_rd);
            led_pad    <= io_wr ? wr_data : led_pad;
        end
    end

`ifdef SW_EDGE_LATCH_EN
    always_ff @(posedge clk) begin
        if (rst) sw_rise <= '0;
        else     sw_rise <= (upd ? (cand & ~sw_stable) : '0) | (sw_rise & ~{SW_W{io_rd}});
    end
`endif
endmodule

// File: tb/tb_sw_led_io_ctrl.sv
// tb_sw_led_io_ctrl: directed stimulus, behavioural run-length model checked every cycle plus literal checks
module tb_sw_led_io_ctrl;
    localparam int D = 4;

    logic        clk = 0, rst = 1;
    logic [7:0]  sw_pad = 8'hFF, wr_data = 0;
    logic [12:0] addr = 0;
    logic        mem_wr = 0, mem_rd = 0;
    logic [7:0]  sw_stable, led_pad;
    logic        sw_changed;
    logic [7:0]  sw_rise_dut;

    int checks = 0, failures = 0;
    bit go = 0;

    sw_led_io_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sw_pad(sw_pad), .addr(addr), .mem_wr(mem_wr),
        .mem_rd(mem_rd), .wr_data(wr_data), .sw_stable(sw_stable),
        .sw_changed(sw_changed), .led_pad(led_pad)
`ifdef SW_EDGE_LATCH_EN
        , .sw_rise(sw_rise_dut)
`endif
    );
`ifndef SW_EDGE_LATCH_EN
    assign sw_rise_dut = 8'h00;
`endif

    always #5 clk = ~clk;

    // Model: switches pass through a 2-deep delay, and a synced value is accepted once it
    // has been seen on D+1 consecutive edges while differing from the accepted value.
    logic [7:0] m_p1, m_p2, m_prev, m_stable, m_led, m_rise, s;
    logic       m_changed, m_upd, m_wr, m_rd;
    int         m_run;
    always @(posedge clk) begin
        if (rst) begin
            m_p1 = 0; m_p2 = 0; m_prev = 0; m_run = 0;
            m_stable = 0; m_changed = 0; m_led = 0; m_rise = 0;
        end else begin
            s      = m_p2;
            m_run  = (s == m_prev) ? m_run + 1 : 1;
            m_prev = s;
            m_upd  = (m_run >= D + 1) && (s != m_stable);
            m_wr   = mem_wr && !mem_rd && addr[8];
            m_rd   = mem_rd && !mem_wr && addr[8];
            m_changed = m_upd || (m_changed && !m_rd);
            m_rise    = (m_upd ? (s & ~m_stable) : 8'h00) | (m_rd ? 8'h00 : m_rise);
            if (m_upd) m_stable = s;
            if (m_wr) m_led = wr_data;
            m_p2 = m_p1;
            m_p1 = sw_pad;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (go) begin
        check("model sw_stable", sw_stable, m_stable);
        check("model sw_changed", {7'b0, sw_changed}, {7'b0, m_changed});
        check("model led_pad", led_pad, m_led);
`ifdef SW_EDGE_LATCH_EN
        check("model sw_rise", sw_rise_dut, m_rise);
`endif
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic io_read;
        addr = 13'h104; mem_rd = 1;
        step(1);
        mem_rd = 0; addr = 0;
    endtask

    initial begin
        step(2);
        check("reset sw_stable", sw_stable, 8'h00);
        check("reset led_pad", led_pad, 8'h00);
        check("reset sw_changed", {7'b0, sw_changed}, 8'h00);
        rst = 0; go = 1;
        step(6);
        check("post-reset latency-1", sw_stable, 8'h00);
        step(1);
        check("post-reset latency", sw_stable, 8'hFF);
        check("post-reset changed", {7'b0, sw_changed}, 8'h01);
        io_read;
        check("io_rd clears", {7'b0, sw_changed}, 8'h00);
        sw_pad = 8'h00;
        step(10);
        check("back to 00", sw_stable, 8'h00);
        io_read;
        // bounce
        sw_pad = 8'h01; step(2);
        sw_pad = 8'h00; step(2);
        sw_pad = 8'h01; step(6);
        check("bounce hold", sw_stable, 8'h00);
        step(1);
        check("bounce accept", sw_stable, 8'h01);
        sw_pad = 8'h00; step(10);
        io_read;
        // mid-count change
        sw_pad = 8'h01; step(3);
        sw_pad = 8'h03; step(6);
        check("midcount hold", sw_stable, 8'h00);
        step(1);
        check("midcount accept", sw_stable, 8'h03);
        io_read;
        // set/clear race
        sw_pad = 8'h00; step(6);
        addr = 13'h104; mem_rd = 1;
        step(1);
        check("race stable", sw_stable, 8'h00);
        check("race set wins", {7'b0, sw_changed}, 8'h01);
        step(1);
        check("later clear", {7'b0, sw_changed}, 8'h00);
        mem_rd = 0;
        // LED stores
        addr = 13'h100; mem_wr = 1; wr_data = 8'hA5; step(1);
        check("led store", led_pad, 8'hA5);
        addr = 13'h0FF; wr_data = 8'h3C; step(1);
        check("led non-io", led_pad, 8'hA5);
        addr = 13'h100; mem_rd = 1; step(1);
        check("led wr+rd", led_pad, 8'hA5);
        mem_wr = 0; mem_rd = 0; addr = 0;
        // edge latch sequence
        sw_pad = 8'h81; step(7);
        check("81 accept", sw_stable, 8'h81);
`ifdef SW_EDGE_LATCH_EN
        check("rise 81", sw_rise_dut, 8'h81);
`endif
        sw_pad = 8'h01; step(7);
        check("01 accept", sw_stable, 8'h01);
`ifdef SW_EDGE_LATCH_EN
        check("rise sticky", sw_rise_dut, 8'h81);
`endif
        io_read;
`ifdef SW_EDGE_LATCH_EN
        check("rise cleared", sw_rise_dut, 8'h00);
`endif
        check("flag cleared", {7'b0, sw_changed}, 8'h00);
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
